// File: rtl/register_file_pc.sv
// Parametrised 3-read/1-write register file with a dedicated auto-incrementing PC slot.
// Reads are combinational with optional write-through bypass; writes commit 1 cycle later.
// No backpressure: every enabled edge commits.
module register_file_pc #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 4,
    parameter int unsigned           NUM_REGS     = 16,
    parameter int unsigned           PC_INDEX     = 15,
    parameter logic [DATA_WIDTH-1:0] PC_INCREMENT = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter bit                    BYPASS       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] port_a,
    output logic [DATA_WIDTH-1:0] port_b,
    output logic [DATA_WIDTH-1:0] port_d,
    output logic [DATA_WIDTH-1:0] pc_out,
    input  logic [ADDR_WIDTH-1:0] a_select,
    input  logic [ADDR_WIDTH-1:0] b_select,
    input  logic [ADDR_WIDTH-1:0] d_select,
    input  logic [DATA_WIDTH-1:0] port_c,
    input  logic [ADDR_WIDTH-1:0] decoder_control,
    input  logic                  load_enable,
    input  logic                  pc_load,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  pc_increment
);

    localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] PC_SEL     = ADDR_WIDTH'(PC_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  wr_en;
    logic                  pc_wr_port;
    logic [ADDR_WIDTH-1:0] rd_sel [3];
    logic [DATA_WIDTH-1:0] rd_dat [3];

    // Gating with reset keeps the bypass from leaking port_c while state is held cleared.
    assign wr_en      = !reset && load_enable && ({1'b0, decoder_control} < NUM_REGS_W);
    assign pc_wr_port = wr_en && (decoder_control == PC_SEL);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[decoder_control] = port_c;
        end
        if (pc_load) begin
            regs_d[PC_INDEX] = pc_in;
        end else if (!pc_wr_port && pc_increment) begin
            regs_d[PC_INDEX] = regs_q[PC_INDEX] + PC_INCREMENT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == PC_INDEX) ? RESET_VECTOR : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_sel = '{a_select, b_select, d_select};

    // A pending pc_load overrides the port write to PC, so the PC slot is not forwarded then.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_dat[p] = '0;
            if ({1'b0, rd_sel[p]} < NUM_REGS_W) begin
                if (BYPASS && wr_en && (rd_sel[p] == decoder_control)
                        && !(pc_load && (rd_sel[p] == PC_SEL))) begin
                    rd_dat[p] = port_c;
                end else begin
                    rd_dat[p] = regs_q[rd_sel[p]];
                end
            end
        end
    end

    assign port_a = rd_dat[0];
    assign port_b = rd_dat[1];
    assign port_d = rd_dat[2];
    assign pc_out = regs_q[PC_INDEX];

endmodule

// File: tb/tb_register_file_pc.sv
// Directed bench: three register_file_pc instances (bypass, no bypass, 12-entry) share one stimulus.
module tb_register_file_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  a_sel, b_sel, d_sel, dc;
    logic [31:0] port_c, pc_in;
    logic        le, pc_load, pc_inc;

    logic [31:0] a0, b0, d0, pc0;
    logic [31:0] a1, b1, d1, pc1;
    logic [31:0] a2, b2, d2, pc2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_file_pc #(.RESET_VECTOR(32'h100), .BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .port_a(a0), .port_b(b0), .port_d(d0), .pc_out(pc0),
        .a_select(a_sel), .b_select(b_sel), .d_select(d_sel), .port_c(port_c),
        .decoder_control(dc), .load_enable(le), .pc_load(pc_load), .pc_in(pc_in),
        .pc_increment(pc_inc));

    register_file_pc #(.RESET_VECTOR(32'h100), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .port_a(a1), .port_b(b1), .port_d(d1), .pc_out(pc1),
        .a_select(a_sel), .b_select(b_sel), .d_select(d_sel), .port_c(port_c),
        .decoder_control(dc), .load_enable(le), .pc_load(pc_load), .pc_in(pc_in),
        .pc_increment(pc_inc));

    register_file_pc #(.NUM_REGS(12), .PC_INDEX(11), .RESET_VECTOR(32'h100)) u_sm (
        .clk(clk), .reset(reset), .port_a(a2), .port_b(b2), .port_d(d2), .pc_out(pc2),
        .a_select(a_sel), .b_select(b_sel), .d_select(d_sel), .port_c(port_c),
        .decoder_control(dc), .load_enable(le), .pc_load(pc_load), .pc_in(pc_in),
        .pc_increment(pc_inc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; drives and samples then sit mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        le = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
        port_c = '0; pc_in = '0; dc = '0;
    endtask

    initial begin
        reset = 1'b1;
        a_sel = '0; b_sel = '0; d_sel = '0;
        idle();

        // Reset state, including edges seen while reset is held.
        #1;
        check("rst_pc", pc0, 32'h100);
        check("rst_a0", a0, 32'h0);
        le = 1'b1; dc = 4'd3; port_c = 32'hDEAD; a_sel = 4'd3;
        #1;
        check("rst_nobypass", a0, 32'h0);
        tick();
        check("rst_edge_ignored", a0, 32'h0);
        idle();
        reset = 1'b0;
        tick();

        // Fill R0..R14 with 1..15.
        for (int k = 0; k < 15; k++) begin
            le = 1'b1; dc = 4'(k); port_c = 32'(k + 1);
            tick();
        end
        idle();
        for (int k = 0; k < 7; k++) begin
            a_sel = 4'(2 * k); b_sel = 4'(2 * k + 1); d_sel = 4'd14;
            #1;
            check($sformatf("fill_a%0d", 2 * k), a0, 32'(2 * k + 1));
            check($sformatf("fill_b%0d", 2 * k + 1), b0, 32'(2 * k + 2));
            check("fill_d14", d0, 32'd15);
        end
        check("fill_pc", pc0, 32'h100);
        check("fill_pc_nb", pc1, 32'h100);

        // PC increment and wrap.
        pc_inc = 1'b1;
        tick(); check("inc1", pc0, 32'h104);
        tick(); check("inc2", pc0, 32'h108);
        tick(); check("inc3", pc0, 32'h10C);
        pc_inc = 1'b0; pc_load = 1'b1; pc_in = 32'hFFFF_FFFC;
        tick(); check("load_fffc", pc0, 32'hFFFF_FFFC);
        pc_load = 1'b0; pc_inc = 1'b1;
        tick(); check("wrap", pc0, 32'h0);

        // Priority: pc_load over port write over increment.
        pc_load = 1'b1; pc_in = 32'h200; le = 1'b1; dc = 4'd15; port_c = 32'h300; pc_inc = 1'b1;
        a_sel = 4'd15;
        #1;
        check("pc_nobypass_on_load", a0, 32'h0);
        tick(); check("prio_load", pc0, 32'h200);
        pc_load = 1'b0;
        #1;
        check("pc_bypass_write", a0, 32'h300);
        check("pc_nb_old", a1, 32'h200);
        tick(); check("prio_write", pc0, 32'h300);
        idle();

        // Same-cycle write-through vs. registered read.
        le = 1'b1; dc = 4'd10; port_c = 32'd7;
        tick();
        port_c = 32'd50; a_sel = 4'd10; b_sel = 4'd10; d_sel = 4'd9;
        #1;
        check("byp_a", a0, 32'd50);
        check("byp_b", b0, 32'd50);
        check("byp_d_other", d0, 32'd10);
        check("nb_a", a1, 32'd7);
        check("nb_b", b1, 32'd7);
        tick();
        idle();
        check("nb_a_after", a1, 32'd50);
        check("byp_a_after", a0, 32'd50);

        // Asynchronous reset between edges discards a pending write.
        le = 1'b1; dc = 4'd5; port_c = 32'h55; pc_load = 1'b1; pc_in = 32'h40;
        tick();
        idle();
        a_sel = 4'd5; b_sel = 4'd14;
        #1;
        check("pre_r5", a0, 32'h55);
        check("pre_pc", pc0, 32'h40);
        le = 1'b1; dc = 4'd5; port_c = 32'hAA; pc_inc = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_r5", a0, 32'h0);
        check("arst_r14", b0, 32'h0);
        check("arst_pc", pc0, 32'h100);
        check("arst_pc_nb", pc1, 32'h100);
        tick();
        check("arst_edge_r5", a0, 32'h0);
        check("arst_edge_pc", pc0, 32'h100);
        idle();
        reset = 1'b0;
        tick();

        // Out-of-range write on the 12-entry instance.
        le = 1'b1; dc = 4'd11; port_c = 32'h11;
        tick();
        dc = 4'd13; port_c = 32'd9; a_sel = 4'd13;
        #1;
        check("oor_sm_nobypass", a2, 32'h0);
        check("oor_full_bypass", a0, 32'd9);
        tick();
        idle();
        b_sel = 4'd11;
        #1;
        check("oor_sm_r13", a2, 32'h0);
        check("oor_sm_r11", b2, 32'h11);
        check("oor_sm_pc", pc2, 32'h11);
        check("oor_full_r13", a0, 32'd9);
        for (int k = 0; k < 11; k++) begin
            a_sel = 4'(k);
            #1;
            check($sformatf("oor_sm_r%0d", k), a2, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_pc.md
Name: register_file_pc

Overview:
- Parametrised successor to the 16x32 datapath register file.
- Adds width/depth parameters, a third read port (D, for store data), asynchronous reset, optional write-through bypass, and a dedicated program-counter register slot.
- The PC slot auto-increments, loads, and is also writable through the normal write port.
- Sits in the data path between instruction decode (selects), the ALU/shifter (ports A/B), the memory interface (port D) and the fetch unit (pc_out).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 4, select width.
- NUM_REGS, 16, implemented registers; legal range 2..2**ADDR_WIDTH.
- PC_INDEX, 15, register index acting as PC; must be < NUM_REGS.
- PC_INCREMENT, 4, amount added on pc_increment.
- RESET_VECTOR, 0, PC value after reset.
- BYPASS, 1, 1 = read ports forward same-cycle port_c write; 0 = read old value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears state immediately, independent of clk.
- port_a  out  DATA_WIDTH  read data for a_select.
- port_b  out  DATA_WIDTH  read data for b_select.
- port_d  out  DATA_WIDTH  read data for d_select.
- pc_out  out  DATA_WIDTH  current contents of R[PC_INDEX].
- a_select  in  ADDR_WIDTH  port A register index.
- b_select  in  ADDR_WIDTH  port B register index.
- d_select  in  ADDR_WIDTH  port D register index.
- port_c  in  DATA_WIDTH  write data.
- decoder_control  in  ADDR_WIDTH  write register index.
- load_enable  in  1  write strobe for port_c.
- pc_load  in  1  load pc_in into PC.
- pc_in  in  DATA_WIDTH  branch target.
- pc_increment  in  1  PC += PC_INCREMENT.

Behaviour:
- Reset (async, level):
  - while reset=1, R[i]=0 for all i != PC_INDEX, and R[PC_INDEX]=RESET_VECTOR;
  - port_a/b/d and pc_out reflect these values combinationally;
  - clock edges during reset are ignored;
  - a reset asserted mid-write wins and no partial update is retained.
- Writes: occur only on the rising clk edge with reset=0, 1-cycle latency. If load_enable=1 and decoder_control < NUM_REGS, R[decoder_control] <= port_c.
- PC register next-value priority (highest first):
  1. pc_load=1: PC <= pc_in.
  2. load_enable=1 and decoder_control==PC_INDEX: PC <= port_c (branch via ALU).
  3. pc_increment=1: PC <= PC + PC_INCREMENT, modulo 2**DATA_WIDTH, wrapping silently (e.g. 0xFFFFFFFC+4 -> 0).
  4. Otherwise PC holds.
- Non-PC registers ignore pc_load and pc_increment.
- Reads: combinational, zero latency, all three ports independent; any combination of equal selects is legal.
- Select >= NUM_REGS: port reads 0. Write with decoder_control >= NUM_REGS is dropped with no side effect.
- Bypass:
  - Applies when BYPASS=1, load_enable=1, decoder_control < NUM_REGS and x_select==decoder_control.
  - Port x then outputs port_c in the same cycle, before the edge.
  - Exception: selects equal to PC_INDEX are not bypassed when pc_load=1 in the same cycle. The port then shows the current PC, not pc_in.
  - pc_load and pc_increment never bypass; pc_out is always the registered value.
  - With BYPASS=0, all reads return the pre-edge registered value.
- No internal state other than the register array. There is no handshake: each enabled edge commits.

Test Plan:
1. Reset then fill: assert reset with RESET_VECTOR=0x100. Then write R0..R14 with values 1..15, one per cycle. Read A=R2k, B=R2k+1, D=R14 -> A=2k+1, B=2k+2, D=15; pc_out=0x100.
2. PC sequencing: pc_increment=1 for 3 cycles from 0x100 -> pc_out 0x104, 0x108, 0x10C. Then one pc_increment cycle starting from 0xFFFFFFFC -> 0x00000000.
3. PC priority: same edge pc_load=1, pc_in=0x200, load_enable=1, decoder_control=15, port_c=0x300, pc_increment=1 -> PC=0x200. Next edge drop pc_load and keep the rest -> PC=0x300.
4. Bypass: R10=7. In one cycle drive port_c=50, decoder_control=10, load_enable=1, a_select=b_select=10. With BYPASS=1, A=B=50 before the edge. With BYPASS=0, A=B=7 before the edge and 50 after.
5. Async reset mid-operation: R5=0x55 and PC=0x40. Assert reset between clock edges -> port_a(sel 5)=0 and pc_out=RESET_VECTOR immediately. A write pending on the next edge while reset is high is discarded.
6. Out-of-range select (NUM_REGS=12): write to index 13 with port_c=9, then read selects 13 and 11 -> select 13 reads 0, R11 is unchanged, and no other register is modified.
